scl_clkgen_filter: RTL and testbench
====================================

// Module: scl_clkgen_filter
// PURPOSE
//  I2C master SCL timing front end for the FMC424 controller.
//  - Generates a free-running standard-mode (100 kHz) SCL square wave for the IOBUF I input.
//  - Conditions the raw SCL pin readback into a clean, edge-annotated signal for the controller FSM.
//  - Sits between fmc_i2c_controller and the top-level SCL IOBUF.
// PARAMETERS
//  CLK_FREQ_HZ    100_000_000  system clock frequency
//  SCL_FREQ_HZ    100_000      generated SCL frequency
//  FILTER_STAGES  2            consecutive equal samples required before scl_filt changes
//  Derived: HALF_PERIOD = CLK_FREQ_HZ/(2*SCL_FREQ_HZ) = 500 cycles at defaults.
// PORTS
//  clk       in   1  system clock, all logic on rising edge
//  reset     in   1  asynchronous, active-high reset
//  en        in   1  1 = SCL generator counts; 0 = generator frozen
//  restart   in   1  synchronous phase realign: SCL forced high, count cleared
//  scl_out   out  1  generated SCL level (drives IOBUF I)
//  scl_in    in   1  raw SCL pin readback (IOBUF O), asynchronous to clk
//  scl_filt  out  1  synchronized, glitch-filtered SCL
//  scl_rise  out  1  one-cycle pulse on 0->1 of scl_filt
//  scl_fall  out  1  one-cycle pulse on 1->0 of scl_filt
// BEHAVIOUR
//  Reset values (asynchronous, take effect immediately on reset):
//   - cnt = 0, scl_out = 1, sync/history flops = all 1, scl_filt = 1, scl_filt_d = 1.
//   - scl_rise = scl_fall = 0; bus idles high, so no edge pulse on reset release.
//  Generator, priority restart > en > hold:
//   - restart = 1: cnt <= 0, scl_out <= 1 next cycle.
//   - en = 1 and cnt == HALF_PERIOD-1: cnt <= 0, scl_out <= ~scl_out.
//   - en = 1 otherwise: cnt <= cnt + 1.
//   - en = 0: cnt and scl_out hold.
//   - cnt width = $clog2(HALF_PERIOD). cnt never exceeds HALF_PERIOD-1.
//   - After reset/restart with en held high, first fall after HALF_PERIOD cycles.
//   - Full period is 2*HALF_PERIOD cycles (10 us); duty cycle exactly 50%.
//   - scl_out is registered; no combinational path from any input.
//  Filter:
//   - scl_in enters a 2-flop synchronizer, then a FILTER_STAGES-deep history shift register.
//   - If every history bit equals v, scl_filt <= v; otherwise scl_filt holds.
//   - Latency from a clean scl_in edge to scl_filt: 2 + FILTER_STAGES cycles (4 cycles = 40 ns at defaults).
//   - Pulses shorter than FILTER_STAGES cycles after synchronization are rejected.
//  Edge detect:
//   - scl_filt_d is scl_filt delayed one cycle.
//   - scl_rise = scl_filt & ~scl_filt_d; scl_fall = ~scl_filt & scl_filt_d.
//   - Exactly one pulse per filtered edge.
//  Independence: the generator and the filter share no state. scl_in is not required to track scl_out,
//   so clock stretching by a slave shows up only on scl_filt.
//  Elaboration checks: $error if HALF_PERIOD < 2 or FILTER_STAGES < 1.
// STRUCTURE
//  - Package i2c_pkg holds CLK_FREQ_HZ and SCL_FREQ_HZ defaults and the HALF_PERIOD function.
//  - Sub-module sync_glitch_filter #(STAGES) covers the synchronizer, history register and scl_filt.
//    It is reused later for the SDA readback.
//  - Generator and edge detect stay inline in the top module.
// TESTING
//  1. Hold reset, then release:
//     scl_out = 1, scl_filt = 1, scl_rise = scl_fall = 0 throughout.
//  2. en = 1 from reset release, scl_in tied to scl_out:
//     scl_out falls at cycle 500 and rises at cycle 1000, period 1000.
//     scl_fall pulses once, 4 cycles after each scl_out fall.
//  3. en = 0 for cycles 200-299:
//     first scl_out fall moves to cycle 600; scl_out does not change while en = 0.
//  4. restart pulse at cycle 700 while scl_out = 0:
//     scl_out = 1 at cycle 701; next fall at cycle 1201.
//  5. scl_in low for 1 cycle: scl_filt stays 1, no pulses.
//     scl_in low for 6 cycles: scl_filt low 4 cycles after the scl_in fall, exactly one scl_fall pulse.
//     One scl_rise pulse 4 cycles after scl_in returns high.
//  6. Async reset asserted mid-count (cnt = 300, scl_out = 0) with no clk edge:
//     scl_out = 1 immediately; cnt restarts from 0 after release.

Source files
------------

// File: rtl/i2c_pkg.sv
// rtl/i2c_pkg.sv - shared I2C timing defaults and divider helper
package i2c_pkg;

  localparam int unsigned CLK_FREQ_HZ = 100_000_000;
  localparam int unsigned SCL_FREQ_HZ = 100_000;

  // Clock cycles per SCL half period.
  function automatic int unsigned half_period(input int unsigned clk_hz,
                                              input int unsigned scl_hz);
    return clk_hz / (2 * scl_hz);
  endfunction

endpackage

// File: rtl/sync_glitch_filter.sv
// rtl/sync_glitch_filter.sv - 2-flop synchronizer plus STAGES-sample glitch filter, idles high
module sync_glitch_filter #(
  parameter int unsigned STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic i_async,
  output logic o_filt
);

  logic [1:0]        r_sync;
  logic              r_filt;
  logic [STAGES-1:0] w_window;

  if (STAGES < 1) begin : g_bad_stages
    $error("sync_glitch_filter: STAGES must be at least 1");
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sync <= 2'b11;
    end else begin
      r_sync <= {r_sync[0], i_async};
    end
  end

  // The window holds the newest synchronized sample plus STAGES-1 older ones,
  // so a clean edge reaches o_filt after 2 + STAGES clocks.
  if (STAGES == 1) begin : g_single
    assign w_window = r_sync[1];
  end else begin : g_multi
    logic [STAGES-2:0] r_hist;
    assign w_window = {r_hist, r_sync[1]};
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        r_hist <= '1;
      end else begin
        r_hist <= w_window[STAGES-2:0];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_filt <= 1'b1;
    end else if (&w_window) begin
      r_filt <= 1'b1;
    end else if (~|w_window) begin
      r_filt <= 1'b0;
    end
  end

  assign o_filt = r_filt;

endmodule

// File: rtl/scl_clkgen_filter.sv
// rtl/scl_clkgen_filter.sv - free-running SCL generator and filtered, edge-annotated SCL readback
module scl_clkgen_filter
  import i2c_pkg::*;
#(
  parameter int unsigned CLK_FREQ_HZ   = i2c_pkg::CLK_FREQ_HZ,
  parameter int unsigned SCL_FREQ_HZ   = i2c_pkg::SCL_FREQ_HZ,
  parameter int unsigned FILTER_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic restart,
  output logic scl_out,
  input  logic scl_in,
  output logic scl_filt,
  output logic scl_rise,
  output logic scl_fall
);

  localparam int unsigned HALF_PERIOD = half_period(CLK_FREQ_HZ, SCL_FREQ_HZ);
  localparam int unsigned CNT_W       = (HALF_PERIOD < 2) ? 1 : $clog2(HALF_PERIOD);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(HALF_PERIOD - 1);

  if (HALF_PERIOD < 2) begin : g_bad_half
    $error("scl_clkgen_filter: HALF_PERIOD must be at least 2");
  end
  if (FILTER_STAGES < 1) begin : g_bad_stages
    $error("scl_clkgen_filter: FILTER_STAGES must be at least 1");
  end

  logic [CNT_W-1:0] r_cnt;
  logic             r_scl_out;
  logic             r_filt_d;
  logic             w_filt;

  // restart beats en so the controller can realign phase even while running.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt     <= '0;
      r_scl_out <= 1'b1;
    end else if (restart) begin
      r_cnt     <= '0;
      r_scl_out <= 1'b1;
    end else if (en) begin
      if (r_cnt == CNT_LAST) begin
        r_cnt     <= '0;
        r_scl_out <= ~r_scl_out;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  sync_glitch_filter #(
    .STAGES (FILTER_STAGES)
  ) u_scl_filter (
    .clk     (clk),
    .reset   (reset),
    .i_async (scl_in),
    .o_filt  (w_filt)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_filt_d <= 1'b1;
    end else begin
      r_filt_d <= w_filt;
    end
  end

  assign scl_out  = r_scl_out;
  assign scl_filt = w_filt;
  assign scl_rise = w_filt & ~r_filt_d;
  assign scl_fall = ~w_filt & r_filt_d;

endmodule

// File: tb/tb_scl_clkgen_filter.sv
// tb/tb_scl_clkgen_filter.sv - directed and table-driven checks of scl_clkgen_filter
module tb_scl_clkgen_filter;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic en = 1'b0;
  logic restart = 1'b0;
  logic scl_in_tb = 1'b1;
  logic tie = 1'b0;
  logic scl_out, scl_in, scl_filt, scl_rise, scl_fall;

  assign scl_in = tie ? scl_out : scl_in_tb;

  scl_clkgen_filter dut (
    .clk      (clk),
    .reset    (reset),
    .en       (en),
    .restart  (restart),
    .scl_out  (scl_out),
    .scl_in   (scl_in),
    .scl_filt (scl_filt),
    .scl_rise (scl_rise),
    .scl_fall (scl_fall)
  );

  always #5 clk = ~clk;

  int n_total = 0;
  int n_pass  = 0;
  int cyc     = 0;
  int filt_low_cnt = 0;
  logic prev_out = 1'b1;
  int tr_cyc[$];
  int tr_val[$];
  int fall_q[$];
  int rise_q[$];

  // Monitor samples 1 time unit after each edge; cyc is the edge number since release.
  always begin
    @(posedge clk);
    #1;
    cyc++;
    if (scl_out !== prev_out) begin
      tr_cyc.push_back(cyc);
      tr_val.push_back(int'(scl_out));
    end
    prev_out = scl_out;
    if (scl_fall) fall_q.push_back(cyc);
    if (scl_rise) rise_q.push_back(cyc);
    if (!scl_filt) filt_low_cnt++;
  end

  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  task automatic clear_log();
    tr_cyc.delete();
    tr_val.delete();
    fall_q.delete();
    rise_q.delete();
    filt_low_cnt = 0;
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic run_to(input int target);
    int guard = 0;
    while (cyc < target && guard < 5000) begin
      step();
      guard++;
    end
    if (cyc != target) chk("run_to_target", cyc, target);
  endtask

  task automatic do_reset(input logic en_val);
    reset = 1'b1;
    restart = 1'b0;
    en = en_val;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    cyc = 0;
    prev_out = 1'b1;
    clear_log();
  endtask

  typedef struct {
    int low_len;
    int exp_falls;
    int exp_rises;
    int exp_fall_lat;
    int exp_rise_lat;
    int exp_low_cycles;
  } filt_vec_t;

  filt_vec_t vecs[4];

  initial begin
    vecs[0] = '{low_len: 1, exp_falls: 0, exp_rises: 0, exp_fall_lat: 0, exp_rise_lat: 0, exp_low_cycles: 0};
    vecs[1] = '{low_len: 2, exp_falls: 1, exp_rises: 1, exp_fall_lat: 4, exp_rise_lat: 4, exp_low_cycles: 2};
    vecs[2] = '{low_len: 6, exp_falls: 1, exp_rises: 1, exp_fall_lat: 4, exp_rise_lat: 4, exp_low_cycles: 6};
    vecs[3] = '{low_len: 3, exp_falls: 1, exp_rises: 1, exp_fall_lat: 4, exp_rise_lat: 4, exp_low_cycles: 3};

    // Reset state, held and after release with the generator frozen.
    #12;
    chk("rst_scl_out", int'(scl_out), 1);
    chk("rst_scl_filt", int'(scl_filt), 1);
    chk("rst_rise", int'(scl_rise), 0);
    chk("rst_fall", int'(scl_fall), 0);
    do_reset(1'b0);
    run_to(20);
    chk("idle_transitions", tr_cyc.size(), 0);
    chk("idle_pulses", fall_q.size() + rise_q.size(), 0);
    chk("idle_filt_low", filt_low_cnt, 0);

    // Free-running with scl_in tied to scl_out.
    tie = 1'b1;
    do_reset(1'b1);
    run_to(1010);
    chk("gen_ntrans", tr_cyc.size(), 2);
    if (tr_cyc.size() == 2) begin
      chk("gen_fall_cyc", tr_cyc[0], 500);
      chk("gen_fall_val", tr_val[0], 0);
      chk("gen_rise_cyc", tr_cyc[1], 1000);
      chk("gen_rise_val", tr_val[1], 1);
    end
    chk("gen_nfall", fall_q.size(), 1);
    if (fall_q.size() == 1) chk("gen_fall_pulse_cyc", fall_q[0], 504);
    chk("gen_nrise", rise_q.size(), 1);
    if (rise_q.size() == 1) chk("gen_rise_pulse_cyc", rise_q[0], 1004);

    // en low for 100 sampled edges delays the first fall by 100.
    do_reset(1'b1);
    run_to(200);
    en = 1'b0;
    run_to(300);
    chk("hold_scl_out", int'(scl_out), 1);
    en = 1'b1;
    run_to(610);
    chk("hold_ntrans", tr_cyc.size(), 1);
    if (tr_cyc.size() == 1) chk("hold_fall_cyc", tr_cyc[0], 600);

    // restart while scl_out is low realigns phase.
    do_reset(1'b1);
    run_to(700);
    chk("pre_restart_out", int'(scl_out), 0);
    restart = 1'b1;
    run_to(701);
    restart = 1'b0;
    chk("restart_out", int'(scl_out), 1);
    run_to(1205);
    chk("restart_ntrans", tr_cyc.size(), 3);
    if (tr_cyc.size() == 3) begin
      chk("restart_rise_cyc", tr_cyc[1], 701);
      chk("restart_fall_cyc", tr_cyc[2], 1201);
    end

    // Async reset mid-count takes effect without a clock edge.
    do_reset(1'b1);
    run_to(800);
    chk("mid_out_low", int'(scl_out), 0);
    reset = 1'b1;
    #1;
    chk("async_rst_out", int'(scl_out), 1);
    chk("async_rst_filt", int'(scl_filt), 1);
    @(negedge clk);
    reset = 1'b0;
    cyc = 0;
    prev_out = 1'b1;
    clear_log();
    run_to(505);
    chk("post_rst_ntrans", tr_cyc.size(), 1);
    if (tr_cyc.size() == 1) chk("post_rst_fall_cyc", tr_cyc[0], 500);

    // Filter vectors with scl_in driven independently and generator frozen.
    tie = 1'b0;
    scl_in_tb = 1'b1;
    do_reset(1'b0);
    run_to(10);
    for (int i = 0; i < 4; i++) begin
      int t0;
      clear_log();
      t0 = cyc;
      scl_in_tb = 1'b0;
      run_to(t0 + vecs[i].low_len);
      scl_in_tb = 1'b1;
      run_to(t0 + vecs[i].low_len + 12);
      chk($sformatf("filt%0d_nfall", i), fall_q.size(), vecs[i].exp_falls);
      chk($sformatf("filt%0d_nrise", i), rise_q.size(), vecs[i].exp_rises);
      chk($sformatf("filt%0d_low_cycles", i), filt_low_cnt, vecs[i].exp_low_cycles);
      if (vecs[i].exp_falls > 0 && fall_q.size() > 0)
        chk($sformatf("filt%0d_fall_lat", i), fall_q[0] - t0, vecs[i].exp_fall_lat);
      if (vecs[i].exp_rises > 0 && rise_q.size() > 0)
        chk($sformatf("filt%0d_rise_lat", i), rise_q[0] - (t0 + vecs[i].low_len), vecs[i].exp_rise_lat);
      chk($sformatf("filt%0d_final", i), int'(scl_filt), 1);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
